// File: rtl/tt_sweep_checker.sv
// Truth-table sweeper: steps a stimulus vector through 0..2^N_IN-1, lets it settle,
// compares a reference and a candidate output, and reports error count and first failure.
module tt_sweep_checker #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop_on_err,
    input  logic [N_OUT-1:0]  ref_in,
    input  logic [N_OUT-1:0]  dut_in,
    output logic [N_IN-1:0]   vec_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic              first_err_valid,
    output logic [N_IN-1:0]   first_err_vec
);

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);

    state_t          state;
    logic [CW-1:0]   settle_cnt;
    logic            soe_q;
    logic            mismatch;

    // Case inequality so an X/Z on either side counts as a failure in simulation.
    assign mismatch = (ref_in !== dut_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            settle_cnt      <= '0;
            soe_q           <= 1'b0;
            vec_out         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= APPLY;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        vec_out         <= '0;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_vec   <= '0;
                        soe_q           <= stop_on_err;
                        settle_cnt      <= SETTLE_LD;
                    end
                end
                APPLY: begin
                    if (settle_cnt == '0) state <= CHECK;
                    else                  settle_cnt <= settle_cnt - 1'b1;
                end
                CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + (N_IN+1)'(1);
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_vec   <= vec_out;
                        end
                    end
                    if ((mismatch && soe_q) || (vec_out == '1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // A mismatch on this last vector is not yet in err_count.
                        pass  <= !mismatch && (err_count == '0);
                    end else begin
                        state      <= APPLY;
                        vec_out    <= vec_out + 1'b1;
                        settle_cnt <= SETTLE_LD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: per-sweep expectations from a small model are queued at
// start and popped when done rises; a second instance covers wide outputs and long settle.
module tb_tt_sweep_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop_on_err;
    logic [0:0]  ref_in, dut_in;
    logic [3:0]  vec_out;
    logic        busy, done, pass;
    logic [4:0]  err_count;
    logic        first_err_valid;
    logic [3:0]  first_err_vec;
    logic [15:0] fault;

    logic        b_start;
    logic [2:0]  b_ref, b_dut;
    logic [1:0]  b_vec;
    logic        b_busy, b_done, b_pass;
    logic [2:0]  b_err;
    logic        b_fev;
    logic [1:0]  b_fvec;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int cyc;
        int err;
        int fvec;
        int fev;
        int pass;
        int last;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign ref_in = vec_out[0] ^ (vec_out[1] & vec_out[3]) ^ vec_out[2];
    assign dut_in = ref_in ^ fault[vec_out];
    assign b_ref  = {b_vec[1] & b_vec[0], b_vec};
    assign b_dut  = ~b_ref;

    tt_sweep_checker #(.N_IN(4), .N_OUT(1), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop_on_err(stop_on_err),
        .ref_in(ref_in), .dut_in(dut_in), .vec_out(vec_out), .busy(busy),
        .done(done), .pass(pass), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_vec(first_err_vec)
    );

    tt_sweep_checker #(.N_IN(2), .N_OUT(3), .SETTLE(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .stop_on_err(1'b0),
        .ref_in(b_ref), .dut_in(b_dut), .vec_out(b_vec), .busy(b_busy),
        .done(b_done), .pass(b_pass), .err_count(b_err),
        .first_err_valid(b_fev), .first_err_vec(b_fvec)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] mask, input logic soe);
        exp_t e;
        e = '{cyc: 0, err: 0, fvec: 0, fev: 0, pass: 0, last: 0};
        for (int v = 0; v < 16; v++) begin
            e.last = v;
            if (mask[v]) begin
                e.err++;
                if (e.fev == 0) begin
                    e.fev  = 1;
                    e.fvec = v;
                end
                if (soe) break;
            end
        end
        e.cyc  = (e.last + 1) * 2;
        e.pass = (e.err == 0) ? 1 : 0;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 with done sampled high (or timed out).
    task automatic run_sweep(input logic [15:0] mask, input logic soe, input bit hold);
        exp_t e;
        int   cyc;
        sb.push_back(model(mask, soe));
        fault       = mask;
        stop_on_err = soe;
        start       = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        chk("busy_rise", busy, 1);
        chk("clr_err", err_count, 0);
        chk("clr_fev", first_err_valid, 0);
        chk("vec0", vec_out, 0);
        cyc = 0;
        while (!done && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        e = sb.pop_front();
        chk("done", done, 1);
        chk("busy_fall", busy, 0);
        chk("latency", cyc, e.cyc);
        chk("err_count", err_count, e.err);
        chk("pass", pass, e.pass);
        chk("first_err_valid", first_err_valid, e.fev);
        chk("first_err_vec", first_err_vec, e.fvec);
        chk("vec_last", vec_out, e.last);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; start = 1'b0; stop_on_err = 1'b0; fault = '0; b_start = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_vec", vec_out, 0);
        chk("rst_err", err_count, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_sweep(16'h0000, 1'b0, 1'b0);                // clean sweep
        run_sweep(16'h0040, 1'b0, 1'b0);                // single fault at 6
        run_sweep(16'h0208, 1'b1, 1'b0);                // stop at first fault (3)
        run_sweep(16'h0208, 1'b0, 1'b0);                // same faults, full sweep
        run_sweep(16'h8000, 1'b0, 1'b0);                // fault on final vector
        run_sweep(16'hA5A5, 1'b0, 1'b1);                // start held through sweep
        @(posedge clk); #1;
        chk("single_sweep_done", done, 1);
        chk("single_sweep_busy", busy, 0);
        run_sweep(16'h0000, 1'b0, 1'b0);                // restart from DONE clears results

        // Asynchronous reset mid-sweep
        fault = '0; stop_on_err = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        cyc = 0;
        while (vec_out != 4'd5 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reach_vec5", vec_out, 5);
        rst_n = 1'b0;
        #1;
        chk("arst_vec", vec_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err_count, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_sweep(16'h0000, 1'b0, 1'b0);

        // Wide-output, long-settle instance with every vector mismatching
        b_start = 1'b1;
        @(posedge clk); #1; b_start = 1'b0;
        chk("b_busy", b_busy, 1);
        cyc = 0;
        while (!b_done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("b_done", b_done, 1);
        chk("b_latency", cyc, 16);
        chk("b_err", b_err, 4);
        chk("b_fev", b_fev, 1);
        chk("b_fvec", b_fvec, 0);
        chk("b_pass", b_pass, 0);
        chk("b_vec", b_vec, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
